// File: rtl/rsa_stream_core.sv
// rsa_stream_core: byte-streamed modular exponentiation (msg^exp mod N).
// Operands arrive MSB-first over a show-ahead UART receive FIFO, and the
// result leaves MSB-first through the transmit FIFO. Exponentiation is a
// constant-time left-to-right square-and-multiply built on a Blakley
// interleaved shift-add modular multiplier.
// Optional build macro RSA_STREAM_TIMEOUT_EN adds an inter-byte receive
// timeout in the LD_* states.
//
// Handshake: rd_uart pops one byte and rx_data is captured on the same
// rising edge; it is raised only while rx_empty=0 and never in two
// consecutive cycles. wr_uart pushes tx_data on the same rising edge; it is
// raised only while tx_full=0 and never in two consecutive cycles.
module rsa_stream_core #(
  parameter int WordSize      = 32,
  parameter int TimeoutCycles = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          rx_data,
  input  logic                rx_empty,
  output logic                rd_uart,
  output logic [7:0]          tx_data,
  input  logic                tx_full,
  output logic                wr_uart,
  output logic [WordSize-1:0] result,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2:0]          o_dbg_state
);

  localparam int W  = WordSize;
  localparam int NB = W / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int SW = $clog2(W + 1);
  localparam int BW = $clog2(W);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LD_MSG, ST_LD_EXP, ST_LD_MOD, ST_CHECK, ST_EXP, ST_SEND, ST_FIN
  } state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_msg, r_exp, r_mod, r_acc, r_mul_a, r_mul_b, r_r;
  logic [W-1:0]    r_result, r_tx_sh;
  logic [CW-1:0]   r_byte_cnt;
  logic [SW-1:0]   r_step;
  logic [BW-1:0]   r_bit_cnt;
  logic            r_phase, r_rd_prev, r_wr_prev, r_error;

  logic            w_ld, w_rd, w_wr, w_last_byte, w_bad, w_exp_last, w_timeout;
  logic [W+1:0]    w_r2, w_r3, w_mod_ext;
  logic [W-1:0]    w_r2m, w_r3m, w_r_next, w_acc_new;

  assign w_ld        = (r_state == ST_LD_MSG) || (r_state == ST_LD_EXP) ||
                       (r_state == ST_LD_MOD);
  assign w_rd        = reset && w_ld && !rx_empty && !r_rd_prev;
  assign w_wr        = reset && (r_state == ST_SEND) && !tx_full && !r_wr_prev;
  assign w_last_byte = (r_byte_cnt == CW'(NB - 1));
  assign w_bad       = (r_mod < W'(2)) || (r_msg >= r_mod);
  assign w_exp_last  = (r_state == ST_EXP) && (r_step == SW'(W)) && r_phase &&
                       (r_bit_cnt == BW'(W - 1));

  // One Blakley iteration: R = 2R mod N, then R = R + B mod N when the
  // multiplier bit is set. R and B are always below N, so one conditional
  // subtraction per step is enough.
  assign w_mod_ext = {2'b00, r_mod};
  assign w_r2      = {1'b0, r_r, 1'b0};
  assign w_r2m     = (w_r2 >= w_mod_ext) ? W'(w_r2 - w_mod_ext) : w_r2[W-1:0];
  assign w_r3      = {2'b00, w_r2m} + {2'b00, r_mul_b};
  assign w_r3m     = (w_r3 >= w_mod_ext) ? W'(w_r3 - w_mod_ext) : w_r3[W-1:0];
  assign w_r_next  = r_mul_a[W-1] ? w_r3m : w_r2m;
  // The product is always computed; only the exponent bit picks whether it is kept.
  assign w_acc_new = r_exp[W-1] ? w_r_next : r_acc;

`ifdef RSA_STREAM_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  assign w_timeout = w_ld && !w_rd && (r_to_cnt >= 32'(TimeoutCycles - 1));

  // Inter-byte timeout: counts cycles since the last pop while loading.
  always_ff @(posedge clk) begin
    if (!reset || !w_ld) r_to_cnt <= '0;
    else if (w_rd)       r_to_cnt <= 32'd1;
    else                 r_to_cnt <= r_to_cnt + 32'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_LD_MSG;
      ST_LD_MSG: if (w_rd && w_last_byte) w_next = ST_LD_EXP;
      ST_LD_EXP: if (w_rd && w_last_byte) w_next = ST_LD_MOD;
      ST_LD_MOD: if (w_rd && w_last_byte) w_next = ST_CHECK;
      ST_CHECK:  w_next = w_bad ? ST_FIN : ST_EXP;
      ST_EXP:    if (w_exp_last) w_next = ST_SEND;
      ST_SEND:   if (w_wr && w_last_byte) w_next = ST_FIN;
      ST_FIN:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_FIN;
  end

  // Datapath: operand loading, exponentiation sequencing, transmit shifter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_msg <= '0; r_exp <= '0; r_mod <= '0; r_acc <= '0;
      r_mul_a <= '0; r_mul_b <= '0; r_r <= '0;
      r_result <= '0; r_tx_sh <= '0; r_byte_cnt <= '0;
      r_step <= '0; r_bit_cnt <= '0; r_phase <= 1'b0;
      r_rd_prev <= 1'b0; r_wr_prev <= 1'b0; r_error <= 1'b0;
    end else begin
      r_rd_prev <= w_rd;
      r_wr_prev <= w_wr;
      case (r_state)
        ST_IDLE: if (start) begin
          r_error    <= 1'b0;
          r_byte_cnt <= '0;
        end
        ST_LD_MSG, ST_LD_EXP, ST_LD_MOD: if (w_rd) begin
          if (r_state == ST_LD_MSG) r_msg <= {r_msg[W-9:0], rx_data};
          if (r_state == ST_LD_EXP) r_exp <= {r_exp[W-9:0], rx_data};
          if (r_state == ST_LD_MOD) r_mod <= {r_mod[W-9:0], rx_data};
          r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + CW'(1);
        end
        ST_CHECK: begin
          if (w_bad) r_error <= 1'b1;
          else begin
            r_acc     <= W'(1);
            r_step    <= '0;
            r_phase   <= 1'b0;
            r_bit_cnt <= '0;
          end
        end
        ST_EXP: begin
          if (r_step == '0) begin
            // Setup: square uses acc*acc, multiply uses acc*msg.
            r_r     <= '0;
            r_mul_a <= r_acc;
            r_mul_b <= r_phase ? r_msg : r_acc;
            r_step  <= SW'(1);
          end else begin
            r_r     <= w_r_next;
            r_mul_a <= r_mul_a << 1;
            if (r_step == SW'(W)) begin
              r_step <= '0;
              if (!r_phase) begin
                r_acc   <= w_r_next;
                r_phase <= 1'b1;
              end else begin
                r_phase   <= 1'b0;
                r_acc     <= w_acc_new;
                r_exp     <= r_exp << 1;
                r_bit_cnt <= r_bit_cnt + BW'(1);
                if (r_bit_cnt == BW'(W - 1)) begin
                  r_result   <= w_acc_new;
                  r_tx_sh    <= w_acc_new;
                  r_byte_cnt <= '0;
                end
              end
            end else begin
              r_step <= r_step + SW'(1);
            end
          end
        end
        ST_SEND: if (w_wr) begin
          r_tx_sh    <= r_tx_sh << 8;
          r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + CW'(1);
        end
        default: ;
      endcase
      if (w_timeout) begin
        r_error    <= 1'b1;
        r_byte_cnt <= '0;
      end
    end
  end

  assign rd_uart     = w_rd;
  assign wr_uart     = w_wr;
  assign tx_data     = (r_state == ST_SEND) ? r_tx_sh[W-1 -: 8] : 8'h00;
  assign result      = r_result;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FIN);
  assign error       = r_error;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rsa_stream_core.sv
// tb_rsa_stream_core: self-checking bench for rsa_stream_core (WordSize=16).
// Models the RX FIFO as a byte queue, checks every TX byte against a
// scoreboard queue filled when each operation is issued.
module tb_rsa_stream_core;

  localparam int W = 16;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_EXP = 3'd5, ST_SEND = 3'd6;

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_empty = 1'b1, tx_full = 1'b0;
  logic         rd_uart, wr_uart, busy, done, error;
  logic [7:0]   tx_data;
  logic [W-1:0] result;
  logic [2:0]   dbg_state;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int done_cnt = 0, wr_cnt = 0, exp_cyc = 0, last_rd_cyc = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit gap_en = 0, pop_req = 0, prev_rd = 0, prev_wr = 0;
  logic [W-1:0] model_res = '0;

  rsa_stream_core #(.WordSize(W), .TimeoutCycles(100)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_empty(rx_empty), .rd_uart(rd_uart), .tx_data(tx_data),
    .tx_full(tx_full), .wr_uart(wr_uart), .result(result), .busy(busy),
    .done(done), .error(error), .o_dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] modexp(input logic [W-1:0] m, input logic [W-1:0] e,
                                          input logic [W-1:0] n);
    longint acc = 1;
    for (int i = W - 1; i >= 0; i--) begin
      acc = (acc * acc) % longint'(n);
      if (e[i]) acc = (acc * longint'(m)) % longint'(n);
    end
    return W'(acc);
  endfunction

  // RX FIFO model: pop after the edge on which the DUT captured the byte.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pop_req && rx_q.size() > 0) void'(rx_q.pop_front());
    pop_req  = 0;
    rx_empty = (rx_q.size() == 0) || (gap_en && $urandom_range(0, 2) == 0);
    rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // Monitor: handshake rules and TX scoreboard.
  always @(negedge clk) begin
    if (rd_uart) begin
      pop_req = 1;
      last_rd_cyc = cyc;
      check("rd_gap", {31'd0, prev_rd}, 0);
      check("rd_when_empty", {31'd0, rx_empty}, 0);
    end
    if (wr_uart) begin
      wr_cnt++;
      check("wr_gap", {31'd0, prev_wr}, 0);
      check("wr_when_full", {31'd0, tx_full}, 0);
      if (exp_q.size() > 0) check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      else check("tx_unexpected", {31'd0, wr_uart}, 0);
    end
    if (done) done_cnt++;
    if (dbg_state == ST_EXP) exp_cyc++;
    prev_rd = rd_uart;
    prev_wr = wr_uart;
  end

  task automatic push_word(input logic [W-1:0] v);
    rx_q.push_back(v[15:8]);
    rx_q.push_back(v[7:0]);
  endtask

  task automatic start_pulse();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    while (!done && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, {31'd0, done}, 1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] e,
                        input logic [W-1:0] n, input logic [W-1:0] exp_res,
                        input bit exp_err, input bit hold_tx);
    int t;
    done_cnt = 0; wr_cnt = 0; exp_cyc = 0;
    push_word(m); push_word(e); push_word(n);
    if (!exp_err) begin
      exp_q.push_back(exp_res[15:8]);
      exp_q.push_back(exp_res[7:0]);
    end
    if (hold_tx) tx_full = 1'b1;
    start_pulse();
    if (hold_tx) begin
      t = 0;
      while (dbg_state != ST_SEND && t < 5000) begin
        @(negedge clk);
        t++;
      end
      check({tag, "_reach_send"}, {29'd0, dbg_state}, {29'd0, ST_SEND});
      repeat (50) @(negedge clk);
      tx_full = 1'b0;
    end
    wait_done(tag, 5000);
    check({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, "_done_pulse"}, done_cnt, 1);
    check({tag, "_wr_count"}, wr_cnt, exp_err ? 0 : 2);
    check({tag, "_tx_left"}, exp_q.size(), 0);
    if (!exp_err) check({tag, "_exp_cycles"}, exp_cyc, 2 * W * (W + 1));
    model_res = exp_res;
  endtask

  initial begin
    logic [W-1:0] rm, re, rn;
    int t;
    // Reset.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", {16'd0, result}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_error", {31'd0, error}, 0);
    check("rst_rd", {31'd0, rd_uart}, 0);
    check("rst_wr", {31'd0, wr_uart}, 0);
    check("rst_txdata", {24'd0, tx_data}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors.
    run_op("encrypt", 16'h0041, 16'h0011, 16'h0CA1, 16'h0AE6, 0, 0);
    run_op("decrypt", 16'h0AE6, 16'h019D, 16'h0CA1, 16'h0041, 0, 0);
    run_op("err_mod1", 16'h0000, 16'h0003, 16'h0001, model_res, 1, 0);
    run_op("err_msg_ge_mod", 16'h0CA1, 16'h0011, 16'h0CA1, model_res, 1, 0);
    run_op("exp_zero", 16'h0005, 16'h0000, 16'h0007, 16'h0001, 0, 0);
    run_op("max_mod", 16'hFFFE, 16'hFFFF, 16'hFFFF, modexp(16'hFFFE, 16'hFFFF, 16'hFFFF), 0, 0);

    // Flow control: RX gaps plus TX FIFO full for 50+ cycles.
    gap_en = 1;
    run_op("flow", 16'h0041, 16'h0011, 16'h0CA1, 16'h0AE6, 0, 1);

    // Random operands checked against the reference model.
    for (int i = 0; i < 4; i++) begin
      rn = W'($urandom_range(2, 16'hFFFF));
      rm = W'($urandom_range(0, int'(rn) - 1));
      re = W'($urandom_range(0, 16'hFFFF));
      run_op("random", rm, re, rn, modexp(rm, re, rn), 0, 0);
    end
    gap_en = 0;

    // Reset in the middle of exponentiation.
    done_cnt = 0; wr_cnt = 0;
    push_word(16'h0041); push_word(16'h0011); push_word(16'h0CA1);
    start_pulse();
    t = 0;
    while (dbg_state != ST_EXP && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("midrst_reach_exp", {29'd0, dbg_state}, {29'd0, ST_EXP});
    repeat (100) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("midrst_result", {16'd0, result}, 0);
    reset = 1'b1;
    model_res = '0;
    repeat (700) @(negedge clk);
    check("midrst_no_tx", wr_cnt, 0);
    check("midrst_no_done", done_cnt, 0);

`ifdef RSA_STREAM_TIMEOUT_EN
    // Timeout: three bytes then silence.
    done_cnt = 0; wr_cnt = 0;
    rx_q.push_back(8'h00); rx_q.push_back(8'h41); rx_q.push_back(8'h00);
    start_pulse();
    wait_done("timeout", 1000);
    check("timeout_latency", cyc - last_rd_cyc, 100);
    check("timeout_error", {31'd0, error}, 1);
    check("timeout_result", {16'd0, result}, {16'd0, model_res});
    @(negedge clk);
    check("timeout_no_tx", wr_cnt, 0);
    run_op("after_timeout", 16'h0041, 16'h0011, 16'h0CA1, 16'h0AE6, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
